// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - first-word-fall-through result buffer with sticky overflow flag
module result_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_full,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data,
   output logic [AW:0]      count,
   output logic             overflow,
   input  logic             ovf_clr
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;

   assign wr_full  = (count == FULL_COUNT);
   assign rd_valid = (count != '0);
   assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

   // Fullness is judged on the pre-edge count, so a same-cycle pop never rescues a push.
   assign push = wr_en & ~wr_full;
   assign pop  = rd_valid & rd_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            count <= count + (AW+1)'(1);
         end else if (pop && !push) begin
            count <= count - (AW+1)'(1);
         end
         // A new drop outranks a clear in the same cycle.
         if (wr_en && wr_full) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: doc/result_fifo.md
Name: result_fifo

Overview:
- Read-side counterpart to the team's enable-loaded register: FPU stages push results with a single-cycle write enable (en/d style); this block buffers them and presents them to a downstream consumer over a valid/ready handshake.
- Sits between the FPU result stage and the writeback/bus interface.
- Absorbs bursts when the consumer stalls and flags any dropped results.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; clock clk.
- wr_en  input  1  push request; one word per asserted cycle.
- wr_data  input  WIDTH  word to push, sampled when wr_en=1.
- wr_full  output  1  entry count equals DEPTH.
- rd_valid  output  1  head word available (count != 0).
- rd_ready  input  1  consumer accepts head word.
- rd_data  output  WIDTH  head word; all zeros when rd_valid=0.
- count  output  AW+1  current entry count, 0..DEPTH.
- overflow  output  1  sticky: a push was dropped.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async, any time, including mid-burst):
  - rd/wr pointers and count go to 0; overflow goes to 0; storage array goes to all zeros.
  - Outputs during reset: wr_full=0, rd_valid=0, rd_data=0.
- Accept rules:
  - push = wr_en & (count < DEPTH).
  - pop = rd_valid & rd_ready.
- Push: storage[wr_ptr] <= wr_data; wr_ptr increments modulo DEPTH (natural AW-bit wrap).
- Pop: rd_ptr increments modulo DEPTH.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a word pushed at edge N is visible at rd_data with rd_valid=1 after edge N (first-word-fall-through, one cycle write-to-read).
- rd_data and rd_valid are combinational from registered pointers/storage; no combinational path from rd_ready or wr_en to any output.
- wr_full and rd_valid are derived from registered count only.
- Full boundary:
  - wr_en=1 with count==DEPTH: word dropped and overflow set at that edge.
  - This holds even if a pop occurs in the same cycle; the full state is decided on the pre-edge count.
  - No pointers or storage change for the dropped word.
- Empty boundary: rd_ready=1 with count==0 is ignored; no pointer movement, no underflow.
- Simultaneous push and pop at 0 < count < DEPTH: both happen; count unchanged.
- At count==0, a push with rd_ready=1 does not pop in the same cycle; the word appears the next cycle.
- Overflow:
  - Set on a dropped push; held until ovf_clr=1 or reset.
  - If ovf_clr and a new drop occur in the same cycle, set wins (overflow=1).
- Ordering: strictly FIFO; words are popped in push order across pointer wrap.
- rd_data holds the head word stable while rd_valid=1 and rd_ready=0.
- Consumers rely on data stability under back-pressure.

Test Plan:
- Reset then single push of 0x3F800000, rd_ready=0 -> next cycle rd_valid=1, rd_data=0x3F800000, count=1; hold 5 cycles -> data stable; rd_ready=1 one cycle -> count=0, rd_valid=0, rd_data=0.
- DEPTH=4: push 0x1,0x2,0x3,0x4 back-to-back, rd_ready=0 -> wr_full=1, count=4; push 0x5 -> dropped, overflow=1, count=4; drain -> reads 0x1..0x4 in order, 0x5 never appears.
- Full with simultaneous wr_en=1 (0x9) and rd_ready=1 -> pop occurs, push dropped, count=3, overflow=1; ovf_clr pulse -> overflow=0; ovf_clr concurrent with another drop -> overflow stays 1.
- Streaming wrap: rd_ready=1 continuously, push 0x10..0x1F one per cycle (16 words, 4 wraps) -> each word is output exactly once, in order, one cycle after its push; count never exceeds 1; overflow=0.
- Reset mid-operation: fill 3 entries, assert rst asynchronously between clock edges -> count=0, rd_valid=0, rd_data=0, overflow=0 immediately; after release, push 0xAA -> read 0xAA only (no stale data).
- Empty pop: count=0, rd_ready=1 for 3 cycles -> count stays 0, pointers unchanged; a subsequent push of 0x55 is read correctly.
